// File: rtl/fp32_defs.sv
// FP32 field widths and constants shared by the multiplier datapath and its arbiter front end.
package fp32_defs;

  localparam int FP32_W    = 32;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int FP32_BIAS = 127;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/Mul.sv
// Combinational FP32 multiplier: truncating, no rounding or special-value handling; zero operand gives +0.
module Mul
  import fp32_defs::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);

  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int HI_W   = MAN_W + 2;

  fp32_t             fa;
  fp32_t             fb;
  logic [PROD_W-1:0] prod;
  logic [HI_W-1:0]   prod_hi;
  logic [EXP_W-1:0]  exp_sum;
  logic [EXP_W-1:0]  exp_n;
  logic [MAN_W-1:0]  man_n;
  logic              zero;

  assign fa = a;
  assign fb = b;

  assign zero    = (a[FP32_W-2:0] == '0) || (b[FP32_W-2:0] == '0);
  assign prod    = PROD_W'({1'b1, fa.man}) * PROD_W'({1'b1, fb.man});
  assign prod_hi = HI_W'(prod >> MAN_W);
  assign exp_sum = fa.expo + fb.expo - EXP_W'(FP32_BIAS);

  Normalizer u_norm (
    .prod_hi (prod_hi),
    .exp_in  (exp_sum),
    .frac    (man_n),
    .expo    (exp_n)
  );

  assign y = zero ? FP32_ZERO : {fa.sign ^ fb.sign, exp_n, man_n};

endmodule

// File: rtl/Normalizer.sv
// Normalizes the top bits of a 24x24 mantissa product: shifts out the hidden bit and bumps the exponent on carry.
module Normalizer
  import fp32_defs::*;
(
  input  logic [MAN_W+1:0] prod_hi,
  input  logic [EXP_W-1:0] exp_in,
  output logic [MAN_W-1:0] frac,
  output logic [EXP_W-1:0] expo
);

  // prod_hi[MAN_W+1] set means the product landed in [2,4): take one bit higher.
  assign frac = prod_hi[MAN_W+1] ? prod_hi[MAN_W:1] : prod_hi[MAN_W-1:0];
  assign expo = exp_in + EXP_W'(prod_hi[MAN_W+1]);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning from ptr, pointer moves past the winner.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr;

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && |req) begin
      ptr <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one combinational FP32 Mul among N requesters: RR grant into an operand stage, then a result stage.
module mul_share_arbiter
  import fp32_defs::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*FP32_W-1:0]   req_a,
  input  logic [N*FP32_W-1:0]   req_b,
  output logic [N-1:0]          req_ready,
  output logic                  resp_valid,
  output logic [FP32_W-1:0]     resp_data,
  output logic [ID_W-1:0]       resp_id,
  input  logic                  resp_ready
);

  logic              s1_valid;
  logic [FP32_W-1:0] s1_a;
  logic [FP32_W-1:0] s1_b;
  logic [ID_W-1:0]   s1_id;

  logic [N-1:0]      gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [FP32_W-1:0] sel_a;
  logic [FP32_W-1:0] sel_b;
  logic [FP32_W-1:0] mul_y;

  logic s2_free;
  logic s1_adv;
  logic s1_free;
  logic grant_en;
  logic accept;

  assign s2_free  = ~resp_valid | resp_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign s1_free  = ~s1_valid | s1_adv;
  // Masking with rst keeps req_ready low and the pointer parked while reset is held.
  assign grant_en = s1_free & ~rst;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (grant_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*FP32_W +: FP32_W];
        sel_b = req_b[i*FP32_W +: FP32_W];
      end
    end
  end

  Mul u_mul (
    .a (s1_a),
    .b (s1_b),
    .y (mul_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      if (s2_free) begin
        resp_valid <= s1_valid;
        if (s1_valid) begin
          resp_data <= mul_y;
          resp_id   <= s1_id;
        end
      end
      if (s1_free) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= gnt_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: per-requester operand model feeding a scoreboard of expected responses.
module tb_mul_share_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [31:0]    resp_data;
  logic [1:0]     resp_id;
  logic           resp_ready;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .N    (N),
    .ID_W (2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          glog[$];
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [31:0] op_p [N];
  int          remaining [N];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          chk_lat = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    op_a[i] = a;
    op_b[i] = b;
    op_p[i] = p;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = remaining[i] > 0;
      req_a[32*i +: 32]  = op_a[i];
      req_b[32*i +: 32]  = op_b[i];
    end
  endtask

  // Observe handshakes mid-cycle, then advance one edge and update the requesters.
  task automatic tick();
    logic [N-1:0] acc;
    exp_t         e;
    @(negedge clk);
    acc = req_valid & req_ready;
    chk("gnt_onehot", 32'($onehot0(req_ready)), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        sb.push_back('{id: i, data: op_p[i], cyc: cyc});
        glog.push_back(i);
      end
    end
    if (resp_valid && resp_ready) begin
      chk("resp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_data", resp_data, e.data);
        if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) remaining[i]--;
    end
    drive();
  endtask

  function automatic bit busy();
    return (sb.size() != 0) || (req_valid != '0);
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (busy() && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    set_op(0, 32'h40000000, 32'h40400000, 32'h40C00000);
    set_op(1, 32'h3FC00000, 32'hC0000000, 32'hC0400000);
    set_op(2, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    set_op(3, 32'hBF800000, 32'hBF800000, 32'h3F800000);
    drive();
    repeat (2) tick();

    // reset state
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_ptr", 32'(u_dut.u_arb.ptr), 32'd0);
    remaining[0] = 1;
    drive();
    #1;
    chk("rst_ready_held", 32'(req_ready), 32'd0);
    tick();

    // single op 2.0 x 3.0
    rst = 1'b0;
    #1;
    chk("t1_grant", 32'(req_ready), 32'h1);
    tick();
    chk("t1_s1_only", 32'(resp_valid), 32'd0);
    drain("t1_drain");

    // sign and zero operands
    set_op(2, 32'h00000000, 32'hC0000000, 32'h00000000);
    remaining[1] = 1;
    remaining[2] = 1;
    drive();
    #1;
    chk("t2_grant", 32'(req_ready), 32'h2);
    drain("t2_drain");

    // fairness: all requesters held continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(2, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    glog.delete();
    for (int i = 0; i < N; i++) remaining[i] = 3;
    drive();
    n = 0;
    while (busy() && n < 60) begin
      tick();
      n++;
    end
    chk("fair_cycles", 32'(n), 32'd14);
    chk("fair_count", 32'(glog.size()), 32'd12);
    for (int k = 0; k < 12 && k < glog.size(); k++) chk("fair_order", 32'(glog[k]), 32'(k % 4));

    // backpressure with 4 ops queued
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) remaining[i] = 1;
    drive();
    tick();
    tick();
    repeat (5) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, 32'h40C00000);
      chk("bp_id", 32'(resp_id), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    chk_lat    = 1'b0;
    drain("bp_drain");
    chk_lat    = 1'b1;

    // reset with both stages full
    resp_ready   = 1'b0;
    remaining[0] = 1;
    remaining[2] = 1;
    drive();
    tick();
    tick();
    chk("t5_s2_full", 32'(resp_valid), 32'd1);
    chk("t5_s1_full", 32'(u_dut.s1_valid), 32'd1);
    rst          = 1'b1;
    remaining[1] = 1;
    remaining[3] = 1;
    drive();
    #1;
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    tick();
    chk("t5_resp_valid", 32'(resp_valid), 32'd0);
    chk("t5_ready_low", 32'(req_ready), 32'd0);
    chk("t5_ptr", 32'(u_dut.u_arb.ptr), 32'd0);
    rst        = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'h2);
    drain("t5_drain");

    // sparse: only requester 3, every other cycle
    set_op(3, 32'h40800000, 32'h3F000000, 32'h40000000);
    for (int r = 0; r < 4; r++) begin
      remaining[3] = 1;
      drive();
      #1;
      chk("t6_grant", 32'(req_ready), 32'h8);
      tick();
      chk("t6_ptr_wrap", 32'(u_dut.u_arb.ptr), 32'd0);
      tick();
    end
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
